// File: rtl/omem_bank_ctrl.sv
`timescale 1ns/1ps
// Output memory for the SNN conv layer: banks spike/residual per pixel and timestep,
// answers SPE requests, broadcasts timestep-done and streams the spike map at the end.
module omem_bank_ctrl #(
  parameter int NUM_SPE     = 5,
  parameter int OUTPUT_SIZE = 21,
  parameter int NUM_TS      = 2,
  parameter int RES_WIDTH   = 13,
  parameter int NUM_DEST    = 11,
  parameter int PKT_W       = 33,
  localparam int NPIX  = OUTPUT_SIZE * OUTPUT_SIZE,
  localparam int TS_W  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1,
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_packet,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_packet,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [TS_W-1:0]  dump_ts,
  output logic [PIX_W-1:0] dump_addr,
  output logic             dump_spike,
  output logic             done,
  output logic             err
);

  localparam int PTR_W  = $clog2(NPIX + NUM_SPE);
  localparam int CNT_W  = $clog2(NPIX + 1);
  localparam int MEM_N  = NUM_TS * NPIX;
  localparam int MEM_AW = (MEM_N > 1) ? $clog2(MEM_N) : 1;
  localparam logic [3:0] OP_TS_DONE = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_RESP, S_BCAST, S_DUMP, S_DONE} state_t;

  function automatic logic [PKT_W-1:0] make_pkt(input logic [3:0] dest, input logic [3:0] opc,
                                               input logic [24:0] data);
    logic [PKT_W-1:0] p;
    p = '0;
    p[32:29] = dest;
    p[28:25] = opc;
    p[24:0]  = data;
    return p;
  endfunction

  state_t              state;
  logic [RES_WIDTH:0]  mem [MEM_N];
  logic [PTR_W-1:0]    ptr [NUM_SPE];
  logic [CNT_W-1:0]    cnt;
  logic [TS_W-1:0]     ts;
  logic [3:0]          bcast_dest;

  logic [3:0]          op;
  logic [3:0]          req_id;
  logic [PTR_W-1:0]    ptr_sel;
  logic                chan_ok, accept, is_store, is_req, ptr_ok, wr_en;
  logic [MEM_AW-1:0]   wr_idx, rd_idx;
  logic [RES_WIDTH:0]  rd_word;
  logic [24:0]         rsp_data;
  logic                dump_last_addr, dump_last, dump_bit;
  logic [TS_W-1:0]     nxt_ts;
  logic [PIX_W-1:0]    nxt_addr;
  logic                unused_pkt_bits;

  assign op              = in_packet[28:25];
  assign req_id          = in_packet[3:0];
  assign unused_pkt_bits = ^in_packet;

  always_comb begin
    ptr_sel = '0;
    chan_ok = 1'b0;
    for (int k = 0; k < NUM_SPE; k++) begin
      if (op[3:1] == 3'(k)) begin
        ptr_sel = ptr[k];
        chan_ok = 1'b1;
      end
    end
  end

  assign accept   = in_valid && in_ready;
  assign is_store = accept && chan_ok && !op[0];
  assign is_req   = accept && chan_ok && op[0];
  assign ptr_ok   = ptr_sel < PTR_W'(NPIX);
  assign wr_en    = is_store && ptr_ok && !reset;
  assign wr_idx   = MEM_AW'(int'(ts) * NPIX + int'(ptr_sel));
  assign rd_idx   = MEM_AW'((int'(ts) - 1) * NPIX + int'(ptr_sel));

  // Timestep 0 has no previous bank, so requests there read as zero.
  always_comb begin
    rd_word = '0;
    if (ts != '0 && ptr_ok) rd_word = mem[rd_idx];
    rsp_data = '0;
    rsp_data[RES_WIDTH:0] = rd_word;
  end

  always_comb begin
    dump_last_addr = (dump_addr == PIX_W'(NPIX - 1));
    nxt_ts   = dump_ts;
    nxt_addr = dump_addr + 1'b1;
    if (dump_last_addr) begin
      nxt_ts   = dump_ts + 1'b1;
      nxt_addr = '0;
    end
  end

  assign dump_last = dump_last_addr && (dump_ts == TS_W'(NUM_TS - 1));
  assign dump_bit  = mem[MEM_AW'(int'(nxt_ts) * NPIX + int'(nxt_addr))][0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= in_packet[RES_WIDTH:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ts         <= '0;
      cnt        <= '0;
      bcast_dest <= '0;
      for (int k = 0; k < NUM_SPE; k++) ptr[k] <= PTR_W'(k);
    end else begin
      case (state)
        S_IDLE: begin
          if (is_store) begin
            if (ptr_ok) begin
              for (int k = 0; k < NUM_SPE; k++)
                if (op[3:1] == 3'(k)) ptr[k] <= ptr_sel + PTR_W'(NUM_SPE);
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(NPIX - 1)) begin
                state      <= S_BCAST;
                in_ready   <= 1'b0;
                out_valid  <= 1'b1;
                bcast_dest <= '0;
                out_packet <= make_pkt(4'd0, OP_TS_DONE, 25'd0);
              end
            end else begin
              err <= 1'b1;
            end
          end else if (is_req) begin
            state      <= S_RESP;
            in_ready   <= 1'b0;
            out_valid  <= 1'b1;
            out_packet <= make_pkt(req_id, req_id, rsp_data);
          end
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_BCAST: begin
          if (out_ready) begin
            if (bcast_dest == 4'(NUM_DEST - 1)) begin
              out_valid <= 1'b0;
              if (ts < TS_W'(NUM_TS - 1)) begin
                ts       <= ts + 1'b1;
                cnt      <= '0;
                for (int k = 0; k < NUM_SPE; k++) ptr[k] <= PTR_W'(k);
                in_ready <= 1'b1;
                state    <= S_IDLE;
              end else begin
                state      <= S_DUMP;
                dump_valid <= 1'b1;
                dump_ts    <= '0;
                dump_addr  <= '0;
                dump_spike <= mem[0][0];
              end
            end else begin
              bcast_dest <= bcast_dest + 1'b1;
              out_packet <= make_pkt(bcast_dest + 1'b1, OP_TS_DONE, 25'd0);
            end
          end
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (dump_last) begin
              dump_valid <= 1'b0;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              dump_ts    <= nxt_ts;
              dump_addr  <= nxt_addr;
              dump_spike <= dump_bit;
            end
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          ts       <= '0;
          cnt      <= '0;
          for (int k = 0; k < NUM_SPE; k++) ptr[k] <= PTR_W'(k);
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omem_bank_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for omem_bank_ctrl: a pixel/timestep array model predicts router
// responses, broadcasts and dump beats; a negedge monitor pops and compares them.
module tb_omem_bank_ctrl;
  localparam int NUM_SPE = 5, OUTPUT_SIZE = 21, NUM_TS = 2, RES_WIDTH = 13;
  localparam int NUM_DEST = 11, PKT_W = 33;
  localparam int NPIX = OUTPUT_SIZE * OUTPUT_SIZE;

  logic             clk = 1'b0, reset = 1'b1;
  logic             in_valid = 1'b0, out_ready = 1'b0, dump_ready = 1'b0;
  logic [PKT_W-1:0] in_packet = '0;
  logic             in_ready, out_valid, dump_valid, dump_spike, done, err;
  logic [PKT_W-1:0] out_packet;
  logic [0:0]       dump_ts;
  logic [8:0]       dump_addr;

  always #5 clk = ~clk;

  omem_bank_ctrl #(.NUM_SPE(NUM_SPE), .OUTPUT_SIZE(OUTPUT_SIZE), .NUM_TS(NUM_TS),
                   .RES_WIDTH(RES_WIDTH), .NUM_DEST(NUM_DEST), .PKT_W(PKT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_ts(dump_ts), .dump_addr(dump_addr),
    .dump_spike(dump_spike), .done(done), .err(err));

  int               n_tests = 0, n_fail = 0;
  logic [PKT_W-1:0] exp_out[$];
  logic [10:0]      exp_dump[$];
  int               exp_done = 0, dump_seen = 0;
  bit               hold_out = 1'b0;

  // Reference model: per-channel store counts give the owned pixel directly.
  int               m_ts = 0, m_total = 0;
  int               m_n [NUM_SPE];
  bit               m_err = 1'b0;
  bit               m_spike [NUM_TS][NPIX];
  logic [RES_WIDTH-1:0] m_res [NUM_TS][NPIX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [PKT_W-1:0] mk(input int dest, input int opc, input logic [24:0] d);
    return {4'(dest), 4'(opc), d};
  endfunction

  task automatic clear_ptrs();
    m_total = 0;
    for (int k = 0; k < NUM_SPE; k++) m_n[k] = 0;
  endtask

  task automatic send(input logic [3:0] op, input logic [24:0] data);
    int n = 0;
    in_packet = {4'($urandom), op, data};
    in_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 4000);
    if (!in_ready) fail_now("in_ready_timeout", "packet never accepted");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic store(input int k, input logic [24:0] d);
    int pix = m_n[k] * NUM_SPE + k;
    if (pix < NPIX) begin
      m_spike[m_ts][pix] = d[0];
      m_res[m_ts][pix]   = d[RES_WIDTH:1];
      m_n[k]++;
      m_total++;
      if (m_total == NPIX) begin
        for (int dst = 0; dst < NUM_DEST; dst++) exp_out.push_back(mk(dst, 15, 25'd0));
        if (m_ts < NUM_TS - 1) begin
          m_ts++;
        end else begin
          for (int t = 0; t < NUM_TS; t++)
            for (int a = 0; a < NPIX; a++) exp_dump.push_back({1'(t), 9'(a), m_spike[t][a]});
          exp_done++;
          m_ts = 0;
        end
        clear_ptrs();
      end
    end else begin
      m_err = 1'b1;
    end
    send(4'(2 * k), d);
  endtask

  task automatic request(input int k, input int id);
    int pix = m_n[k] * NUM_SPE + k;
    logic [24:0] d  = '0;
    logic [24:0] sd = 25'($urandom);
    if (m_ts > 0) d[RES_WIDTH:0] = {m_res[m_ts-1][pix], m_spike[m_ts-1][pix]};
    exp_out.push_back(mk(id, id, d));
    sd[3:0] = 4'(id);
    send(4'(2 * k + 1), sd);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_out.size() != 0 || exp_dump.size() != 0 || exp_done != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_out_left"}, exp_out.size(), 0);
    check({name, "_dump_left"}, exp_dump.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Fills the remainder of the current timestep in random channel order with side traffic.
  task automatic fill(input bit spike_pat, input bit force37, input bit stall);
    int rem = NPIX - m_total;
    for (int i = 0; i < rem; i++) begin
      int r = $urandom_range(0, 15);
      int k = $urandom_range(0, NUM_SPE - 1);
      int pix;
      logic [24:0] d = 25'($urandom);
      if (r == 0) begin
        send(4'($urandom_range(10, 15)), 25'($urandom));
      end else if (r == 1) begin
        int kk = $urandom_range(0, NUM_SPE - 1);
        if (m_n[kk] * NUM_SPE + kk < NPIX) request(kk, $urandom_range(0, 15));
      end
      while (m_n[k] * NUM_SPE + k >= NPIX) k = (k + 1) % NUM_SPE;
      pix = m_n[k] * NUM_SPE + k;
      if (spike_pat) d[0] = 1'(pix % 2);
      if (force37 && k == 1 && m_n[1] == 0) begin
        d[RES_WIDTH:1] = 13'd37;
        d[0] = 1'b1;
      end
      if (stall && i == rem - 1) hold_out = 1'b1;
      store(k, d);
    end
    if (stall) begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("bcast_start_valid", out_valid, 1);
      repeat (4) @(negedge clk);
      hold_out = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready  = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
      dump_ready = ($urandom_range(0, 1) == 1);
    end
  end

  bit               stall_prev = 1'b0, done_prev = 1'b0;
  logic [PKT_W-1:0] stall_pkt;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
        done_prev  = 1'b0;
      end else begin
        if (stall_prev) begin
          check("out_hold_valid", out_valid, 1);
          check("out_hold_stable", out_packet, stall_pkt);
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) fail_now("out_unexpected", $sformatf("got 0x%0h, required none", out_packet));
          else check("out_pkt", out_packet, exp_out.pop_front());
        end
        stall_prev = out_valid && !out_ready;
        stall_pkt  = out_packet;
        if (dump_valid && dump_ready) begin
          dump_seen++;
          if (exp_dump.size() == 0) fail_now("dump_unexpected", $sformatf("got ts=%0d addr=%0d", dump_ts, dump_addr));
          else check("dump_beat", {dump_ts, dump_addr, dump_spike}, exp_dump.pop_front());
        end
        if (done) begin
          check("done_width", done_prev, 0);
          if (exp_done == 0) fail_now("done_unexpected", "got done=1, required 0");
          else begin
            exp_done--;
            check("done_after_last_beat", exp_dump.size(), 0);
          end
        end
        done_prev = done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    clear_ptrs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    request(4, 4);
    wait_drain("req_ts0");

    fill(1'b1, 1'b1, 1'b1);
    wait_drain("bcast_ts0");
    request(1, 7);
    wait_drain("req_ts1");
    fill(1'b1, 1'b0, 1'b0);
    wait_drain("dump_run1");
    @(negedge clk);
    check("idle_after_done", in_ready, 1);
    check("err_after_run1", err, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 89; i++) store(0, 25'($urandom));
    @(negedge clk);
    check("err_before_overflow", err, m_err);
    @(posedge clk);
    #1;
    store(0, 25'($urandom));
    @(negedge clk);
    check("err_after_overflow", err, m_err);
    check("idle_after_overflow", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ts = 0;
    m_err = 1'b0;
    clear_ptrs();
    @(negedge clk);
    check("err_cleared_by_reset", err, m_err);
    @(posedge clk);
    #1;

    dump_seen = 0;
    fill(1'b0, 1'b0, 1'b0);
    fill(1'b0, 1'b0, 1'b0);
    begin
      int n = 0;
      while (dump_seen < 100 && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("dump_reached_100", dump_seen >= 100, 1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_dump.delete();
    exp_out.delete();
    exp_done = 0;
    m_ts = 0;
    m_err = 1'b0;
    clear_ptrs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_dump_valid", dump_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    snap = dump_seen;
    repeat (20) @(negedge clk);
    check("midreset_no_more_beats", dump_seen, snap);
    @(posedge clk);
    #1;
    request(4, 4);
    request(2, 9);
    wait_drain("req_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/omem_bank_ctrl.md
Name: omem_bank_ctrl

Overview:
Clocked, parametrised output memory for the SNN convolution layer, sitting on the router between the SPEs and the testbench. It stores a spike bit and a residual potential per output pixel, per timestep, for NUM_SPE interleaved SPE channels. It answers SPE requests for the previous timestep's spike and residual. When a timestep completes it broadcasts timestep-done packets, and after the last timestep it streams every stored spike to the testbench.

Parameters:
NUM_SPE, 5, number of SPE channels; SPE k owns pixels k, k+NUM_SPE, k+2*NUM_SPE, ...
OUTPUT_SIZE, 21, output map side; the map holds NPIX = OUTPUT_SIZE*OUTPUT_SIZE pixels
NUM_TS, 2, number of timesteps held in banks
RES_WIDTH, 13, stored residual width; must be 24 or less
NUM_DEST, 11, number of node IDs (0..NUM_DEST-1) that receive the timestep-done packet
PKT_W, 33, packet width; fields are dest[32:29], opcode[28:25], data[24:0]

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  router packet valid
in_ready  out  1  block can accept a packet
in_packet  in  PKT_W  incoming router packet
out_valid  out  1  outgoing router packet valid
out_ready  in  1  router accepts the outgoing packet
out_packet  out  PKT_W  outgoing router packet
dump_valid  out  1  testbench spike beat valid
dump_ready  in  1  testbench accepts the beat
dump_ts  out  clog2(NUM_TS)  timestep of the beat
dump_addr  out  clog2(NPIX)  pixel index of the beat
dump_spike  out  1  stored spike bit
done  out  1  one-cycle pulse after the final dump beat
err  out  1  sticky flag: a store was dropped because the pointer overflowed

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- Reset values:
  - out_valid=0, dump_valid=0, done=0, err=0, in_ready=1.
  - State IDLE, ts=0, ptr_k=k for every channel, store count=0.
  - Memory contents are not cleared. Reads of unwritten locations are don't-care, except that ts=0 requests return 0.
- Handshakes:
  - A transfer occurs on a rising edge when valid&&ready.
  - Once raised, a valid holds and its payload stays stable until the transfer.
  - in_ready=1 only in IDLE.
- State machine: IDLE, RESP, BCAST, DUMP, DONE.
- IDLE, when a packet is accepted, decode op=in_packet[28:25]:
  - op=2k, k<NUM_SPE (store):
    - If ptr_k<NPIX: write spike=data[0] and residual=data[RES_WIDTH:1] (upper bits truncated) into bank[ts][ptr_k] at that edge. Then ptr_k+=NUM_SPE and count+=1.
    - Otherwise: drop the store, set err, leave count unchanged.
    - If count reaches NPIX, go to BCAST on the next cycle.
  - op=2k+1, k<NUM_SPE (request):
    - Requester id = data[3:0]. Go to RESP.
    - out_packet: dest=id, opcode=id, data[0]=spike and data[RES_WIDTH:1]=residual from bank[ts-1][ptr_k] (both 0 when ts=0). Remaining data bits are 0.
    - out_valid rises the cycle after acceptance. ptr_k does not advance.
  - Any other opcode (including 15 and channels k>=NUM_SPE): consumed and ignored, no state change.
- RESP: hold until out_ready, then return to IDLE.
- BCAST:
  - Send NUM_DEST packets, dest=0..NUM_DEST-1 in ascending order, opcode=15, data=0. One packet per transfer; out_valid stays high between packets.
  - After the last transfer:
    - If ts<NUM_TS-1: ts+=1, ptr_k=k, count=0, go to IDLE.
    - Otherwise: go to DUMP.
- DUMP:
  - Beats in order t=0..NUM_TS-1, then addr=0..NPIX-1 within each t: dump_ts=t, dump_addr=addr, dump_spike=bank[t][addr].
  - This gives NUM_TS*NPIX beats. The next beat is presented the cycle after each transfer.
- DONE: done=1 for exactly one cycle. Then ts=0, ptr_k=k, count=0, go to IDLE. err is not cleared.
- A reset asserted in any state, including mid-BCAST or mid-DUMP, drops valids on the next edge and restores all reset values.
- Storage layout: the bank is a register array of NUM_TS*NPIX entries, each RES_WIDTH+1 bits wide.

Test Plan:
- Reset behaviour: reset 3 cycles -> in_ready=1, out_valid=0, dump_valid=0, err=0.
- Store then request: store op=2 (SPE1), data={res=37, spike=1} at ts0. After the full ts0 broadcast, send op=3 with id=7 -> response dest=7, opcode=7, data[0]=1, data[13:1]=37.
- Timestep completion and broadcast:
  - Send 441 round-robin stores (SPE0..4), holding out_ready low for 4 cycles at broadcast start.
  - Required: 11 packets, dest 0..10, opcode 15, with out_packet stable while stalled.
  - ts becomes 1 and ptr_k returns to k.
- Pointer overflow: send 90 stores from SPE0 -> the 89th store is accepted at ptr=440; the 90th is dropped and err=1.
- Request at ts0: send op=9 with id=4 at ts0 -> data=0, dest=4.
- Full run and mid-dump reset:
  - Complete ts0 and ts1 with the pattern spike=addr%2. With dump_ready toggling, expect 882 beats in order with dump_spike=addr%2, then a single-cycle done.
  - Rerun and assert reset at beat 100 -> dump_valid=0 next cycle, state IDLE, ts=0.
